multichannel_handshake_sender: RTL and testbench

- N-channel source-side front end for a 4-phase req/ack clock-domain crossing.
- Round-robin arbitrates between CHANNELS local producers, each using a start/ready handshake.
- Captures the winning word plus its channel index and drives the 4-phase req/ack protocol toward an external receiver in another clock domain.
- Synchronises ack_i internally, and adds an ack-timeout with a sticky error flag.

---
 rtl/multichannel_handshake_sender.sv | 189 ++++++++++++++++++
 tb/tb_multichannel_handshake_sender.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multichannel_handshake_sender.sv
// Source-side front end of a 4-phase req/ack clock-domain crossing.
// Round-robin arbitration picks one of CHANNELS start/ready producers. The
// winning word and its channel index are captured, then sent with req_o.
// The asynchronous ack_i is synchronised locally, and a REQ phase that sees
// no ack within TIMEOUT_CYCLES is aborted with a sticky error.
module multichannel_handshake_sender #(
    parameter int WIDTH          = 32,
    parameter int CHANNELS       = 4,
    parameter int NUM_OF_STAGES  = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic [CHANNELS-1:0]                   start,
    output logic [CHANNELS-1:0]                   ready,
    input  logic [CHANNELS*WIDTH-1:0]             data_in,
    output logic [WIDTH-1:0]                      data_out,
    output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] chan_out,
    output logic                                  req_o,
    input  logic                                  ack_i,
    output logic                                  busy,
    output logic                                  timeout_err,
    input  logic                                  err_clear
);

    localparam int CHAN_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    // The counter only has to reach TIMEOUT_CYCLES-1.
    localparam int CNT_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [CHAN_W-1:0] CHAN_LAST = CHAN_W'(CHANNELS - 1);
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        ACK_LOW = 2'd2
    } state_t;

    state_t                      state_r, state_nxt;
    logic [NUM_OF_STAGES-1:0]    sync_r;
    logic                        ack_s;
    logic                        req_r, req_nxt;
    logic [WIDTH-1:0]            data_r, data_nxt;
    logic [CHAN_W-1:0]           chan_r, chan_nxt;
    logic [CHAN_W-1:0]           ptr_r, ptr_nxt;
    logic [CNT_W-1:0]            cnt_r, cnt_nxt;
    logic                        err_r, err_nxt;
    logic                        busy_r;
    logic                        set_err_s;
    logic                        grant_valid_s;
    logic [CHAN_W-1:0]           grant_s;
    logic [CHANNELS-1:0]         ready_s;
    logic [WIDTH-1:0]            words_s [CHANNELS];

    // Unpack the flat input bus into one word per channel.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_words
        assign words_s[i] = data_in[i*WIDTH +: WIDTH];
    end

    // Shift ack_i through the synchroniser chain; only its last flop is used.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[NUM_OF_STAGES-2:0], ack_i};
        end
    end

    assign ack_s = sync_r[NUM_OF_STAGES-1];

    // Round-robin search: the first asserted start scanning upward from ptr_r.
    always_comb begin
        int idx;
        grant_valid_s = 1'b0;
        grant_s       = '0;
        idx           = 0;
        for (int k = 0; k < CHANNELS; k++) begin
            idx = (int'(ptr_r) + k >= CHANNELS) ? int'(ptr_r) + k - CHANNELS : int'(ptr_r) + k;
            if (!grant_valid_s && start[idx]) begin
                grant_valid_s = 1'b1;
                grant_s       = CHAN_W'(idx);
            end else begin
                grant_valid_s = grant_valid_s;
            end
        end
    end

    // A grant is offered only in IDLE once any earlier ack has been seen to fall.
    always_comb begin
        ready_s = '0;
        if (!reset && (state_r == IDLE) && !ack_s && grant_valid_s) begin
            ready_s[grant_s] = 1'b1;
        end else begin
            ready_s = '0;
        end
    end

    assign ready = ready_s;

    // Compute the next FSM state and the next value of every register it owns.
    always_comb begin
        state_nxt = state_r;
        req_nxt   = req_r;
        data_nxt  = data_r;
        chan_nxt  = chan_r;
        ptr_nxt   = ptr_r;
        cnt_nxt   = cnt_r;
        set_err_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (!ack_s && grant_valid_s) begin
                    data_nxt  = words_s[grant_s];
                    chan_nxt  = grant_s;
                    req_nxt   = 1'b1;
                    ptr_nxt   = (grant_s == CHAN_LAST) ? '0 : grant_s + CHAN_W'(1);
                    cnt_nxt   = '0;
                    state_nxt = REQ;
                end else begin
                    state_nxt = IDLE;
                end
            end
            REQ: begin
                cnt_nxt = cnt_r + CNT_W'(1);
                if (ack_s) begin
                    req_nxt   = 1'b0;
                    state_nxt = ACK_LOW;
                end else if (TIMEOUT_EN && (cnt_r == CNT_LAST)) begin
                    req_nxt   = 1'b0;
                    set_err_s = 1'b1;
                    state_nxt = ACK_LOW;
                end else begin
                    state_nxt = REQ;
                end
            end
            ACK_LOW: begin
                req_nxt = 1'b0;
                if (!ack_s) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    state_nxt = ACK_LOW;
                end
            end
            default: begin
                req_nxt   = 1'b0;
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
        // Setting the error wins over a simultaneous clear.
        if (set_err_s) begin
            err_nxt = 1'b1;
        end else if (err_clear) begin
            err_nxt = 1'b0;
        end else begin
            err_nxt = err_r;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
            req_r   <= 1'b0;
            data_r  <= '0;
            chan_r  <= '0;
            ptr_r   <= '0;
            cnt_r   <= '0;
            err_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt;
            req_r   <= req_nxt;
            data_r  <= data_nxt;
            chan_r  <= chan_nxt;
            ptr_r   <= ptr_nxt;
            cnt_r   <= cnt_nxt;
            err_r   <= err_nxt;
            busy_r  <= (state_nxt != IDLE);
        end
    end

    assign req_o       = req_r;
    assign data_out    = data_r;
    assign chan_out    = chan_r;
    assign busy        = busy_r;
    assign timeout_err = err_r;

endmodule

// File: tb/tb_multichannel_handshake_sender.sv
// Self-checking bench for multichannel_handshake_sender. A transaction-level
// model tracks the pending requests, the fair-share pointer and each
// channel's word. A bench-side receiver answers req_o with random delays.
module tb_multichannel_handshake_sender;

    localparam int W   = 32;
    localparam int C   = 4;
    localparam int STG = 2;
    localparam int TO  = 16;

    logic             clock = 1'b0;
    logic             reset;
    logic [C-1:0]     start;
    logic [C-1:0]     ready;
    logic [C*W-1:0]   data_in;
    logic [W-1:0]     data_out;
    logic [1:0]       chan_out;
    logic             req_o;
    logic             ack_i;
    logic             busy;
    logic             timeout_err;
    logic             err_clear;

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    logic [C-1:0] pend;
    logic [W-1:0] mdata [C];
    int           mptr;

    multichannel_handshake_sender #(
        .WIDTH(W), .CHANNELS(C), .NUM_OF_STAGES(STG), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .ready(ready),
        .data_in(data_in), .data_out(data_out), .chan_out(chan_out),
        .req_o(req_o), .ack_i(ack_i), .busy(busy),
        .timeout_err(timeout_err), .err_clear(err_clear)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_inputs();
        start = pend;
        for (int i = 0; i < C; i++) data_in[i*W +: W] = mdata[i];
    endtask

    // Raise new requests; a freshly raised request carries a fresh random word.
    task automatic set_pend(input logic [C-1:0] v);
        for (int i = 0; i < C; i++) begin
            if (v[i] && !pend[i]) mdata[i] = $urandom;
        end
        pend = pend | v;
    endtask

    // Fair share: the first pending channel at or after the pointer, wrapping.
    function automatic int exp_grant();
        for (int k = 0; k < C; k++) begin
            int idx = (mptr + k) % C;
            if (pend[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic reset_dut();
        reset = 1'b1;
        ack_i = 1'b0;
        err_clear = 1'b0;
        pend = '0;
        drive_inputs();
        repeat (2) tick();
        reset = 1'b0;
        mptr = 0;
    endtask

    // One full transfer: grant, capture, receiver ack after dly cycles, release.
    task automatic run_transfer(input int dly, output int g);
        int n;
        int w;
        logic [C-1:0] oh;
        drive_inputs();
        #1;
        g = exp_grant();
        oh = '0;
        if (g >= 0) oh[g] = 1'b1;
        check_eq("ready_grant", ready, oh);
        if (g < 0) return;
        tick();
        check_eq("req_rise", req_o, 1);
        check_eq("busy_req", busy, 1);
        check_eq("data_out", data_out, mdata[g]);
        check_eq("chan_out", chan_out, g);
        pend[g] = 1'b0;
        mptr = (g + 1) % C;
        drive_inputs();
        if (dly < 0) dly = $urandom_range(0, 4);
        repeat (dly) begin
            tick();
            check_eq("req_hold", req_o, 1);
        end
        ack_i = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (req_o && n < 10);
        check_eq("ack_to_req_fall", n, STG + 1);
        w = $urandom_range(0, 3);
        repeat (w) begin
            tick();
            check_eq("acklow_ready", ready, 0);
        end
        ack_i = 1'b0;
        repeat (STG) tick();
        check_eq("busy_hold", busy, 1);
        tick();
        check_eq("busy_drop", busy, 0);
    endtask

    // One transfer that the receiver never acknowledges.
    task automatic run_timeout(input bit clr_on_abort);
        int g;
        int n;
        logic [C-1:0] v;
        pend = '0;
        g = $urandom_range(0, C - 1);
        v = '0;
        v[g] = 1'b1;
        set_pend(v);
        drive_inputs();
        #1;
        check_eq("to_ready", ready, v);
        tick();
        check_eq("to_req_rise", req_o, 1);
        check_eq("to_chan", chan_out, g);
        pend = '0;
        mptr = (g + 1) % C;
        drive_inputs();
        n = 0;
        do begin
            if (n == TO - 1) begin
                check_eq("to_err_before", timeout_err, 0);
                if (clr_on_abort) err_clear = 1'b1;
            end
            tick();
            n++;
        end while (req_o && n < TO + 8);
        check_eq("to_req_cycles", n, TO);
        check_eq("to_err_set", timeout_err, 1);
        check_eq("to_busy_acklow", busy, 1);
        err_clear = 1'b0;
        tick();
        check_eq("to_busy_drop", busy, 0);
        check_eq("to_err_sticky", timeout_err, 1);
    endtask

    initial begin
        int g;
        int ord1 [5] = '{0, 1, 2, 3, 0};
        int ord2 [3] = '{1, 3, 1};
        logic [C-1:0] v;
        logic [C-1:0] oh;

        reset = 1'b1;
        ack_i = 1'b0;
        err_clear = 1'b0;
        pend = '0;
        mptr = 0;
        for (int i = 0; i < C; i++) mdata[i] = '0;
        start = '1;
        data_in = '1;
        repeat (2) tick();
        check_eq("rst_ready", ready, 0);
        check_eq("rst_req", req_o, 0);
        check_eq("rst_data", data_out, 0);
        check_eq("rst_chan", chan_out, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_err", timeout_err, 0);

        // Single transfer from channel 2.
        reset_dut();
        set_pend(4'b0100);
        mdata[2] = 32'hDEADBEEF;
        run_transfer(3, g);
        check_eq("single_chan", g, 2);

        // Fairness with every channel requesting.
        reset_dut();
        for (int i = 0; i < 5; i++) begin
            set_pend(4'b1111);
            run_transfer(-1, g);
            check_eq("rr_all", g, ord1[i]);
        end

        // Fairness with channels 1 and 3 requesting.
        reset_dut();
        for (int i = 0; i < 3; i++) begin
            set_pend(4'b1010);
            run_transfer(-1, g);
            check_eq("rr_odd", g, ord2[i]);
        end

        // Random traffic.
        for (int i = 0; i < 40; i++) begin
            v = 4'($urandom_range(1, 15));
            set_pend(v);
            run_transfer(-1, g);
        end

        // Timeout followed by an explicit clear.
        run_timeout(1'b0);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        check_eq("err_cleared", timeout_err, 0);

        // Timeout with a clear on the abort cycle: setting the error wins.
        run_timeout(1'b1);

        // Late ack after the abort must hold off new grants.
        repeat (4) tick();
        ack_i = 1'b1;
        repeat (STG) begin
            tick();
            check_eq("late_ready_a", ready, 0);
        end
        v = 4'($urandom_range(1, 15));
        set_pend(v);
        drive_inputs();
        #1;
        repeat (10 - STG) begin
            check_eq("late_ready_b", ready, 0);
            check_eq("late_busy", busy, 0);
            tick();
        end
        ack_i = 1'b0;
        repeat (STG - 1) begin
            tick();
            check_eq("late_ready_c", ready, 0);
        end
        tick();
        g = exp_grant();
        oh = '0;
        oh[g] = 1'b1;
        check_eq("late_ready_open", ready, oh);
        run_transfer(-1, g);

        // Reset in the middle of REQ.
        check_eq("err_before_rst", timeout_err, 1);
        pend = '0;
        set_pend(4'b0100);
        drive_inputs();
        tick();
        pend = '0;
        drive_inputs();
        check_eq("mid_req", req_o, 1);
        tick();
        reset = 1'b1;
        start = '1;
        tick();
        check_eq("mrst_req", req_o, 0);
        check_eq("mrst_data", data_out, 0);
        check_eq("mrst_chan", chan_out, 0);
        check_eq("mrst_busy", busy, 0);
        check_eq("mrst_err", timeout_err, 0);
        check_eq("mrst_ready", ready, 0);
        reset = 1'b0;
        mptr = 0;
        set_pend(4'b1111);
        run_transfer(-1, g);
        check_eq("mrst_ptr", g, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
